stats_arb_sched: RTL

Shares one statistics counter block between several statistics collectors, such as per-interface PCIe TLP stats collectors. It arbitrates their AXI-stream stat-increment outputs round-robin into a single registered stream and prefixes each counter ID with the source port index. It also schedules staggered `update` pulses to each collector so their flushes do not collide. It sits between the per-interface stats collectors and the shared stats counter RAM.

---
 rtl/stats_arb_sched.sv | 102 ++++++++++
 1 files changed

// File: rtl/stats_arb_sched.sv
// Round-robin merge of per-collector stat increments into one stream (tid gets port prefix), plus staggered update pulses.
// Latency: one cycle from input handshake to m_axis; update_out is registered one cycle after the counter match.
// Backpressure: only the round-robin winner sees tready, and only when the output register is empty or draining.
module stats_arb_sched #(
    parameter int PORTS          = 4,
    parameter int STAT_INC_WIDTH = 24,
    parameter int STAT_ID_WIDTH  = 5,
    parameter int UPDATE_PERIOD  = 1024,
    parameter int DROP_ZERO      = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PORTS*STAT_INC_WIDTH-1:0]   s_axis_stat_tdata,
    input  logic [PORTS*STAT_ID_WIDTH-1:0]    s_axis_stat_tid,
    input  logic [PORTS-1:0]                  s_axis_stat_tvalid,
    output logic [PORTS-1:0]                  s_axis_stat_tready,
    output logic [STAT_INC_WIDTH-1:0]         m_axis_stat_tdata,
    output logic [STAT_ID_WIDTH+$clog2(PORTS)-1:0] m_axis_stat_tid,
    output logic                              m_axis_stat_tvalid,
    input  logic                              m_axis_stat_tready,
    input  logic                              update,
    output logic [PORTS-1:0]                  update_out
);

    localparam int PORT_W  = $clog2(PORTS);
    localparam int STAGGER = UPDATE_PERIOD / PORTS;
    localparam int CNT_W   = $clog2(UPDATE_PERIOD);

    logic [PORT_W-1:0]         ptr;
    logic [CNT_W-1:0]          cnt;
    logic                      grant_vld;
    logic [PORT_W-1:0]         grant_idx;
    logic                      can_load;
    logic                      xfer;
    logic [STAT_INC_WIDTH-1:0] sel_dat;
    logic [STAT_ID_WIDTH-1:0]  sel_tid;

    // Modular add for port indices; b never exceeds PORTS so one subtraction suffices.
    function automatic logic [PORT_W-1:0] wrap_add(input logic [PORT_W-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= PORTS)
            s = s - PORTS;
        return s[PORT_W-1:0];
    endfunction

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int off = 0; off < PORTS; off++) begin
            if (!grant_vld && s_axis_stat_tvalid[wrap_add(ptr, off)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_add(ptr, off);
            end
        end
    end

    assign can_load = !m_axis_stat_tvalid || m_axis_stat_tready;
    assign xfer     = grant_vld && can_load;
    assign sel_dat  = s_axis_stat_tdata[grant_idx*STAT_INC_WIDTH +: STAT_INC_WIDTH];
    assign sel_tid  = s_axis_stat_tid[grant_idx*STAT_ID_WIDTH +: STAT_ID_WIDTH];

    always_comb begin
        s_axis_stat_tready = '0;
        if (xfer)
            s_axis_stat_tready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr                <= '0;
            cnt                <= '0;
            m_axis_stat_tvalid <= 1'b0;
            m_axis_stat_tdata  <= '0;
            m_axis_stat_tid    <= '0;
            update_out         <= '0;
        end else begin
            if (xfer) begin
                ptr <= wrap_add(grant_idx, 1);
                // A dropped zero still consumes the slot, so a draining output simply empties.
                if (DROP_ZERO != 0 && sel_dat == '0) begin
                    m_axis_stat_tvalid <= 1'b0;
                end else begin
                    m_axis_stat_tdata  <= sel_dat;
                    m_axis_stat_tid    <= {grant_idx, sel_tid};
                    m_axis_stat_tvalid <= 1'b1;
                end
            end else if (m_axis_stat_tready) begin
                m_axis_stat_tvalid <= 1'b0;
            end

            if (cnt == CNT_W'(UPDATE_PERIOD - 1))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            for (int i = 0; i < PORTS; i++)
                update_out[i] <= (cnt == CNT_W'(i * STAGGER)) || update;
        end
    end

endmodule
